// File: rtl/life_engine.sv
// life_engine: 8x8 Game of Life generation engine with a double-buffered board.
// The front board is served to the display by row address; each generation
// is built row by row into the back board and then copied over in one cycle,
// so the displayed board never changes part-way through a generation.
module life_engine #(
  parameter int unsigned TICK_DIV = 25000000,
  parameter int unsigned WRAP     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_en,
  input  logic [2:0]  load_addr,
  input  logic [7:0]  load_row,
  input  logic        run,
  input  logic        step,
  input  logic [2:0]  rd_addr,
  output logic [7:0]  rd_row,
  output logic        busy,
  output logic [15:0] gen_count,
  output logic        extinct
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_SWAP    = 2'd2
  } state_t;

  localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);
  localparam logic        WRAP_ON   = (WRAP != 0);

  // Bit c of the result is the cell at column c-1 (the west neighbour of c).
  function automatic logic [7:0] west_of(input logic [7:0] v);
    logic fill;
    fill = WRAP_ON ? v[7] : 1'b0;
    return {v[6:0], fill};
  endfunction

  // Bit c of the result is the cell at column c+1 (the east neighbour of c).
  function automatic logic [7:0] east_of(input logic [7:0] v);
    logic fill;
    fill = WRAP_ON ? v[0] : 1'b0;
    return {fill, v[7:1]};
  endfunction

  // Next state of all 8 cells of 'mid', given the rows above and below.
  function automatic logic [7:0] life_row(input logic [7:0] up,
                                          input logic [7:0] mid,
                                          input logic [7:0] dn);
    logic [7:0] nb [8];
    logic [7:0] res;
    logic [3:0] n;
    nb[0] = west_of(up);
    nb[1] = up;
    nb[2] = east_of(up);
    nb[3] = west_of(mid);
    nb[4] = east_of(mid);
    nb[5] = west_of(dn);
    nb[6] = dn;
    nb[7] = east_of(dn);
    res = '0;
    for (int c = 0; c < 8; c++) begin
      n = '0;
      for (int k = 0; k < 8; k++) begin
        n = n + {3'b000, nb[k][c]};
      end
      res[c] = (n == 4'd3) | (mid[c] & (n == 4'd2));
    end
    return res;
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  row_q, row_d;
  logic [31:0] tick_cnt_q, tick_cnt_d;
  logic [15:0] gen_count_q, gen_count_d;
  logic [7:0]  front_q [8];
  logic [7:0]  front_d [8];
  logic [7:0]  back_q [8];
  logic [7:0]  back_d [8];
  logic [7:0]  rd_row_q, rd_row_d;
  logic        busy_q, busy_d;
  logic        extinct_q, extinct_d;
  logic        tick;
  logic [7:0]  up_row, dn_row;
  logic        any_live;

  // Next-state logic: tick divider, FSM transitions, board updates and outputs.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    tick_cnt_d  = tick_cnt_q;
    gen_count_d = gen_count_q;
    front_d     = front_q;
    back_d      = back_q;
    tick        = 1'b0;
    any_live    = 1'b0;

    // Neighbouring rows of the row being computed; edges read dead without wrap.
    if (!WRAP_ON && row_q == 3'd0) begin
      up_row = '0;
    end else begin
      up_row = front_q[row_q - 3'd1];
    end
    if (!WRAP_ON && row_q == 3'd7) begin
      dn_row = '0;
    end else begin
      dn_row = front_q[row_q + 3'd1];
    end

    // The divider only advances while idle and running; dropping run clears it.
    if (!run) begin
      tick_cnt_d = '0;
    end else if (state_q == S_IDLE) begin
      if (tick_cnt_q == TICK_LAST) begin
        tick_cnt_d = '0;
        tick       = 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q + 32'd1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (load_en) begin
          front_d[load_addr] = load_row;
        end else if (step || tick) begin
          state_d = S_COMPUTE;
          row_d   = 3'd0;
        end
      end
      S_COMPUTE: begin
        back_d[row_q] = life_row(up_row, front_q[row_q], dn_row);
        row_d         = row_q + 3'd1;
        if (row_q == 3'd7) begin
          state_d = S_SWAP;
        end
      end
      S_SWAP: begin
        front_d     = back_q;
        gen_count_d = gen_count_q + 16'd1;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    for (int r = 0; r < 8; r++) begin
      any_live = any_live | (|front_d[r]);
    end

    rd_row_d  = front_q[rd_addr];
    busy_d    = (state_d != S_IDLE);
    extinct_d = ~any_live;
  end

  // State, board and registered outputs; reset clears everything, including boards.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      tick_cnt_q  <= '0;
      gen_count_q <= '0;
      for (int r = 0; r < 8; r++) begin
        front_q[r] <= '0;
        back_q[r]  <= '0;
      end
      rd_row_q    <= '0;
      busy_q      <= 1'b0;
      extinct_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      tick_cnt_q  <= tick_cnt_d;
      gen_count_q <= gen_count_d;
      front_q     <= front_d;
      back_q      <= back_d;
      rd_row_q    <= rd_row_d;
      busy_q      <= busy_d;
      extinct_q   <= extinct_d;
    end
  end

  assign rd_row    = rd_row_q;
  assign busy      = busy_q;
  assign gen_count = gen_count_q;
  assign extinct   = extinct_q;

endmodule

// File: tb/tb_life_engine.sv
// Testbench for life_engine: a toroidal and a bounded instance share stimulus
// and are compared against a cell-by-cell Life model kept in the bench.
module tb_life_engine;

  logic        clk;
  logic        reset;
  logic        load_en;
  logic [2:0]  load_addr;
  logic [7:0]  load_row;
  logic        run;
  logic        step;
  logic [2:0]  rd_addr;
  logic [7:0]  rd_row_w, rd_row_n;
  logic        busy_w, busy_n;
  logic [15:0] gen_w, gen_n;
  logic        extinct_w, extinct_n;

  int n_checks;
  int n_pass;

  // Reference boards (toroidal and bounded), generation count, and DUT readback.
  logic [7:0] mw [8];
  logic [7:0] mn [8];
  int         mg;
  logic [7:0] rw [8];
  logic [7:0] rn [8];

  life_engine #(.TICK_DIV(4), .WRAP(1)) u_wrap (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_row(load_row), .run(run), .step(step), .rd_addr(rd_addr),
    .rd_row(rd_row_w), .busy(busy_w), .gen_count(gen_w), .extinct(extinct_w)
  );

  life_engine #(.TICK_DIV(4), .WRAP(0)) u_nowrap (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_row(load_row), .run(run), .step(step), .rd_addr(rd_addr),
    .rd_row(rd_row_n), .busy(busy_n), .gen_count(gen_n), .extinct(extinct_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int r = 0; r < 8; r++) begin
      mw[r] = '0;
      mn[r] = '0;
    end
    mg = 0;
  endtask

  // One Life generation from first principles on both reference boards.
  task automatic model_gen();
    logic [7:0] nw [8];
    logic [7:0] nn [8];
    int cw, cn, rr, cc;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        cw = 0;
        cn = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) begin
              rr = r + dr;
              cc = c + dc;
              cw += int'(mw[3'((rr + 8) % 8)][3'((cc + 8) % 8)]);
              if (rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
                cn += int'(mn[3'(rr)][3'(cc)]);
            end
          end
        end
        nw[r][c] = (cw == 3) || (mw[r][c] && cw == 2);
        nn[r][c] = (cn == 3) || (mn[r][c] && cn == 2);
      end
    end
    for (int r = 0; r < 8; r++) begin
      mw[r] = nw[r];
      mn[r] = nn[r];
    end
    mg = (mg + 1) % 65536;
  endtask

  function automatic logic model_dead_w();
    logic any;
    any = 1'b0;
    for (int r = 0; r < 8; r++) any = any | (|mw[r]);
    return ~any;
  endfunction

  function automatic logic model_dead_n();
    logic any;
    any = 1'b0;
    for (int r = 0; r < 8; r++) any = any | (|mn[r]);
    return ~any;
  endfunction

  task automatic do_reset();
    reset   = 1'b1;
    load_en = 1'b0;
    step    = 1'b0;
    run     = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
    model_clear();
  endtask

  task automatic do_load(input logic [2:0] a, input logic [7:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_row  = d;
    cycle();
    load_en = 1'b0;
    mw[a] = d;
    mn[a] = d;
  endtask

  // Pulse step and wait until the swap has landed (engine back in IDLE).
  task automatic do_step();
    step = 1'b1;
    cycle();
    step = 1'b0;
    repeat (9) cycle();
    model_gen();
  endtask

  task automatic read_board();
    for (int r = 0; r < 8; r++) begin
      rd_addr = 3'(r);
      cycle();
      rw[r] = rd_row_w;
      rn[r] = rd_row_n;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (busy_w !== 1'b0 || busy_n !== 1'b0)
      $display("FAIL reset_busy: got %b/%b want 0", busy_w, busy_n);
    else n_pass++;
    n_checks++;
    if (gen_w !== 16'd0 || gen_n !== 16'd0)
      $display("FAIL reset_gen: got %0d/%0d want 0", gen_w, gen_n);
    else n_pass++;
    n_checks++;
    if (extinct_w !== 1'b1 || extinct_n !== 1'b1)
      $display("FAIL reset_extinct: got %b/%b want 1", extinct_w, extinct_n);
    else n_pass++;
    read_board();
    for (int r = 0; r < 8; r++) begin
      n_checks++;
      if (rw[r] !== 8'h00 || rn[r] !== 8'h00)
        $display("FAIL reset_row%0d: got %h/%h want 00", r, rw[r], rn[r]);
      else n_pass++;
    end
  endtask

  task automatic test_blinker();
    do_reset();
    do_load(3'd2, 8'b0001_1100);
    for (int g = 1; g <= 2; g++) begin
      do_step();
      read_board();
      for (int r = 0; r < 8; r++) begin
        n_checks++;
        if (rw[r] !== mw[r] || rn[r] !== mn[r])
          $display("FAIL blinker_g%0d_row%0d: got %h/%h want %h/%h", g, r, rw[r], rn[r], mw[r], mn[r]);
        else n_pass++;
      end
      n_checks++;
      if (gen_w !== 16'(mg) || gen_n !== 16'(mg))
        $display("FAIL blinker_gen%0d: got %0d/%0d want %0d", g, gen_w, gen_n, mg);
      else n_pass++;
    end
  endtask

  task automatic test_block_run();
    int cyc;
    do_reset();
    do_load(3'd3, 8'h18);
    do_load(3'd4, 8'h18);
    run = 1'b1;
    cyc = 0;
    while (gen_w != 16'd1 && cyc < 100) begin
      cycle();
      cyc++;
    end
    n_checks++;
    if (cyc != 13)
      $display("FAIL block_first_tick_latency: got %0d cycles want 13", cyc);
    else n_pass++;
    cyc = 0;
    while (gen_w != 16'd3 && cyc < 200) begin
      cycle();
      cyc++;
    end
    run = 1'b0;
    n_checks++;
    if (cyc >= 200)
      $display("FAIL block_run_timeout: gen %0d after %0d cycles want 3", gen_w, cyc);
    else n_pass++;
    repeat (3) model_gen();
    repeat (20) cycle();
    read_board();
    for (int r = 0; r < 8; r++) begin
      n_checks++;
      if (rw[r] !== mw[r] || rn[r] !== mn[r])
        $display("FAIL block_row%0d: got %h/%h want %h/%h", r, rw[r], rn[r], mw[r], mn[r]);
      else n_pass++;
    end
    n_checks++;
    if (gen_w !== 16'd3 || gen_n !== 16'd3)
      $display("FAIL block_gen: got %0d/%0d want 3", gen_w, gen_n);
    else n_pass++;
    n_checks++;
    if (extinct_w !== 1'b0 || extinct_n !== 1'b0)
      $display("FAIL block_extinct: got %b/%b want 0", extinct_w, extinct_n);
    else n_pass++;
  endtask

  task automatic test_glider();
    logic [7:0] orig [8];
    do_reset();
    do_load(3'd0, 8'h02);
    do_load(3'd1, 8'h04);
    do_load(3'd2, 8'h07);
    for (int r = 0; r < 8; r++) orig[r] = mw[r];
    repeat (32) do_step();
    read_board();
    for (int r = 0; r < 8; r++) begin
      n_checks++;
      if (rw[r] !== orig[r])
        $display("FAIL glider_wrap_row%0d: got %h want %h", r, rw[r], orig[r]);
      else n_pass++;
      n_checks++;
      if (rn[r] !== mn[r])
        $display("FAIL glider_nowrap_row%0d: got %h want %h", r, rn[r], mn[r]);
      else n_pass++;
    end
    n_checks++;
    if (gen_w !== 16'(mg))
      $display("FAIL glider_gen: got %0d want %0d", gen_w, mg);
    else n_pass++;
  endtask

  task automatic test_busy_priority();
    int nbusy;
    do_reset();
    do_load(3'd2, 8'h1C);
    step = 1'b1;
    cycle();
    step  = 1'b0;
    nbusy = 0;
    for (int k = 0; k < 20; k++) begin
      if (busy_w === 1'b1 && busy_n === 1'b1) nbusy++;
      if (k == 2 || k == 3) begin
        step      = 1'b1;
        load_en   = 1'b1;
        load_addr = 3'd0;
        load_row  = 8'hFF;
      end else begin
        step    = 1'b0;
        load_en = 1'b0;
      end
      cycle();
    end
    model_gen();
    n_checks++;
    if (nbusy != 9)
      $display("FAIL busy_cycles: got %0d want 9", nbusy);
    else n_pass++;
    n_checks++;
    if (gen_w !== 16'd1 || gen_n !== 16'd1)
      $display("FAIL busy_step_ignored: gen %0d/%0d want 1", gen_w, gen_n);
    else n_pass++;
    read_board();
    for (int r = 0; r < 8; r++) begin
      n_checks++;
      if (rw[r] !== mw[r] || rn[r] !== mn[r])
        $display("FAIL busy_row%0d: got %h/%h want %h/%h", r, rw[r], rn[r], mw[r], mn[r]);
      else n_pass++;
    end
    load_en   = 1'b1;
    step      = 1'b1;
    load_addr = 3'd5;
    load_row  = 8'h81;
    cycle();
    load_en = 1'b0;
    step    = 1'b0;
    mw[5] = 8'h81;
    mn[5] = 8'h81;
    n_checks++;
    if (busy_w !== 1'b0 || busy_n !== 1'b0)
      $display("FAIL load_step_busy: got %b/%b want 0", busy_w, busy_n);
    else n_pass++;
    repeat (12) cycle();
    n_checks++;
    if (gen_w !== 16'd1 || gen_n !== 16'd1)
      $display("FAIL load_step_gen: got %0d/%0d want 1", gen_w, gen_n);
    else n_pass++;
    read_board();
    n_checks++;
    if (rw[5] !== mw[5] || rn[5] !== mn[5])
      $display("FAIL load_step_row5: got %h/%h want %h", rw[5], rn[5], mw[5]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_compute();
    do_reset();
    do_load(3'd1, 8'h3C);
    do_load(3'd2, 8'h24);
    do_load(3'd6, 8'h0E);
    do_step();
    step = 1'b1;
    cycle();
    step = 1'b0;
    repeat (4) cycle();
    n_checks++;
    if (busy_w !== 1'b1 || gen_w !== 16'd1)
      $display("FAIL midreset_pre: busy %b gen %0d want 1 1", busy_w, gen_w);
    else n_pass++;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    model_clear();
    n_checks++;
    if (busy_w !== 1'b0 || busy_n !== 1'b0)
      $display("FAIL midreset_busy: got %b/%b want 0", busy_w, busy_n);
    else n_pass++;
    n_checks++;
    if (gen_w !== 16'd0 || gen_n !== 16'd0 || extinct_w !== 1'b1 || extinct_n !== 1'b1)
      $display("FAIL midreset_state: gen %0d/%0d ext %b/%b want 0 1", gen_w, gen_n, extinct_w, extinct_n);
    else n_pass++;
    repeat (12) cycle();
    read_board();
    for (int r = 0; r < 8; r++) begin
      n_checks++;
      if (rw[r] !== 8'h00 || rn[r] !== 8'h00)
        $display("FAIL midreset_row%0d: got %h/%h want 00", r, rw[r], rn[r]);
      else n_pass++;
    end
  endtask

  task automatic test_extinct();
    do_reset();
    do_load(3'd4, 8'h10);
    n_checks++;
    if (extinct_w !== 1'b0 || extinct_n !== 1'b0)
      $display("FAIL extinct_after_load: got %b/%b want 0", extinct_w, extinct_n);
    else n_pass++;
    for (int g = 1; g <= 2; g++) begin
      do_step();
      n_checks++;
      if (extinct_w !== model_dead_w() || extinct_n !== model_dead_n())
        $display("FAIL extinct_g%0d: got %b/%b want %b/%b", g, extinct_w, extinct_n, model_dead_w(), model_dead_n());
      else n_pass++;
      n_checks++;
      if (gen_w !== 16'(mg) || gen_n !== 16'(mg))
        $display("FAIL extinct_gen%0d: got %0d/%0d want %0d", g, gen_w, gen_n, mg);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int nsteps;
    do_reset();
    for (int it = 0; it < 8; it++) begin
      for (int r = 0; r < 8; r++) begin
        if (it == 3) do_load(3'(r), 8'(($urandom % 2 == 0) ? 0 : $urandom_range(0, 255) & $urandom_range(0, 255)));
        else do_load(3'(r), 8'($urandom_range(0, 255)));
      end
      nsteps = $urandom_range(1, 4);
      repeat (nsteps) do_step();
      read_board();
      for (int r = 0; r < 8; r++) begin
        n_checks++;
        if (rw[r] !== mw[r] || rn[r] !== mn[r])
          $display("FAIL rand%0d_row%0d: got %h/%h want %h/%h", it, r, rw[r], rn[r], mw[r], mn[r]);
        else n_pass++;
      end
      n_checks++;
      if (gen_w !== 16'(mg) || gen_n !== 16'(mg))
        $display("FAIL rand%0d_gen: got %0d/%0d want %0d", it, gen_w, gen_n, mg);
      else n_pass++;
      n_checks++;
      if (extinct_w !== model_dead_w() || extinct_n !== model_dead_n())
        $display("FAIL rand%0d_extinct: got %b/%b want %b/%b", it, extinct_w, extinct_n, model_dead_w(), model_dead_n());
      else n_pass++;
    end
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    reset     = 1'b1;
    load_en   = 1'b0;
    load_addr = '0;
    load_row  = '0;
    run       = 1'b0;
    step      = 1'b0;
    rd_addr   = '0;
    model_clear();
    test_reset();
    test_blinker();
    test_block_run();
    test_glider();
    test_busy_priority();
    test_reset_mid_compute();
    test_extinct();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
